// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote, optional even parity,
// stop-bit checking and a small receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
   parameter int DATA       = 8,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int PARITY_EN  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_in,
   input  logic            rx_ready,
   output logic [DATA-1:0] rx_data,
   output logic            rx_valid,
   output logic            rx_busy,
   output logic            parity_error,
   output logic            frame_error,
   output logic            overrun,
   output logic [2:0]      state_dbg
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int BW      = (DATA > 1) ? $clog2(DATA) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t state, state_nx;

   logic            rx_s1, rx_s2, rx_prev;
   logic [1:0]      fill;
   logic            start_edge;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [3:0]      smp_cnt;
   logic            s7, s8, maj;
   logic            decide, bit_end;
   logic [DATA-1:0] shreg;
   logic [BW-1:0]   bit_idx;
   logic            par_fail;
   logic            good, pe_nx, fe_nx, ov_nx;

   logic [DATA-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, pop, push, writable;

   // A start edge only counts once the synchronizer holds real line samples, so a line
   // that is already low when reset is released cannot launch a frame.
   assign start_edge = (fill == 2'd3) && rx_prev && !rx_s2;
   assign tick       = (state != S_IDLE) && (div_cnt == DIV_LAST);
   assign maj        = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
   assign decide     = tick && (smp_cnt == 4'd9);
   assign bit_end    = tick && (smp_cnt == 4'd15);

   assign full     = (count == FULL_CNT);
   assign rx_valid = (count != '0);
   assign pop      = rx_valid && rx_ready;
   assign writable = !full || pop;
   assign push     = good && writable;
   assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
   assign rx_busy  = (state != S_IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      good     = 1'b0;
      pe_nx    = 1'b0;
      fe_nx    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_edge) state_nx = S_START;
         end
         S_START: begin
            if (decide && maj) state_nx = S_IDLE;
            else if (bit_end) state_nx = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_idx == LAST_BIT))
               state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (bit_end) state_nx = S_STOP;
         end
         S_STOP: begin
            // Act at the stop-bit centre so the next start edge is never missed.
            if (decide) begin
               state_nx = S_IDLE;
               if (!maj) begin
                  fe_nx    = 1'b1;
                  state_nx = S_BREAK;
               end else if (par_fail) begin
                  pe_nx = 1'b1;
               end else begin
                  good = 1'b1;
               end
            end
         end
         S_BREAK: begin
            if (rx_s2) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      ov_nx = good && !writable;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b1;
         fill         <= 2'd0;
         div_cnt      <= '0;
         smp_cnt      <= 4'd0;
         s7           <= 1'b1;
         s8           <= 1'b1;
         shreg        <= '0;
         bit_idx      <= '0;
         par_fail     <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         rx_s1   <= rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         if (fill != 2'd3) fill <= fill + 2'd1;

         if (state == S_IDLE || tick) div_cnt <= '0;
         else                         div_cnt <= div_cnt + DW'(1);

         if (state == S_IDLE) smp_cnt <= 4'd0;
         else if (tick)       smp_cnt <= smp_cnt + 4'd1;

         if (tick && smp_cnt == 4'd7) s7 <= rx_s2;
         if (tick && smp_cnt == 4'd8) s8 <= rx_s2;

         if (state == S_IDLE && start_edge) begin
            bit_idx  <= '0;
            par_fail <= 1'b0;
         end
         if (state == S_DATA && decide)  shreg   <= {maj, shreg[DATA-1:1]};
         if (state == S_DATA && bit_end) bit_idx <= bit_idx + BW'(1);
         if (state == S_PARITY && decide) par_fail <= (^shreg) ^ maj;

         parity_error <= pe_nx;
         frame_error  <= fe_nx;
         overrun      <= ov_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are driven bit by bit, expected bytes are
// queued at send time and a monitor pops and compares on every accepted output beat.
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic       rx_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       parity_error;
   logic       frame_error;
   logic       overrun;
   logic [2:0] state_dbg;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int pe_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   uart_rx_fifo #(
      .DATA(8), .CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY_EN(1), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
      .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      #1;
      if (reset) begin
         if (rx_valid && rx_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_beat: got %0h, required no data", rx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rx_data !== e) begin
                  n_errors++;
                  $display("FAIL rx_data_beat: got %0h, required %0h", rx_data, e);
               end
            end
         end
         if (parity_error) pe_cnt++;
         if (frame_error)  fe_cnt++;
         if (overrun)      ov_cnt++;
      end
   end

   // drivers
   task automatic send_bits(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop);
      send_bits(1'b0, 16);
      for (int i = 0; i < 8; i++) send_bits(d[i], 16);
      send_bits((^d) ^ par_inv, 16);
      send_bits(stop, 16);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      #2;
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] frames [4];
      logic       busy_seen;
      frames[0] = 8'hD3; frames[1] = 8'hA5; frames[2] = 8'h3C; frames[3] = 8'h55;

      reset = 1'b0; rx_in = 1'b1; rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_busy", rx_busy, 0);
      check("reset_parity_error", parity_error, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_overrun", overrun, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // four good frames back to back
      for (int i = 0; i < 4; i++) exp_q.push_back(frames[i]);
      for (int i = 0; i < 4; i++) send_frame(frames[i], 1'b0, 1'b1);
      wait_drain("b2b_drain", 100);
      check("b2b_pe", pe_cnt, 0);
      check("b2b_fe", fe_cnt, 0);
      check("b2b_ov", ov_cnt, 0);
      check("empty_rx_data", rx_data, 0);

      // bad parity
      send_frame(8'hA5, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      check("par_pe", pe_cnt, 1);
      check("par_rx_valid", rx_valid, 0);
      check("par_fe", fe_cnt, 0);

      // stop bit low, then line held low
      send_frame(8'h3C, 1'b0, 1'b0);
      send_bits(1'b0, 40 * 16);
      #1;
      check("brk_busy_held", rx_busy, 1);
      check("brk_fe_once", fe_cnt, 1);
      check("brk_pe_none", pe_cnt, 1);
      send_bits(1'b1, 6);
      #1;
      check("brk_busy_release", rx_busy, 0);
      check("brk_rx_valid", rx_valid, 0);

      // overrun with stalled consumer
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      #1;
      check("ovr_pulse", ov_cnt, 1);
      check("ovr_head_valid", rx_valid, 1);
      check("ovr_head_data", rx_data, 8'h01);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      @(negedge clk);
      rx_ready = 1'b1;
      wait_drain("ovr_drain", 20);
      check("ovr_empty", rx_valid, 0);

      // glitch -> false start
      busy_seen = 1'b0;
      rx_in = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 3) rx_in = 1'b1;
         if (rx_busy) busy_seen = 1'b1;
      end
      #1;
      check("glitch_busy_seen", busy_seen, 1);
      check("glitch_busy_low", rx_busy, 0);
      check("glitch_pe", pe_cnt, 1);
      check("glitch_fe", fe_cnt, 1);
      check("glitch_ov", ov_cnt, 1);
      check("glitch_no_data", rx_valid, 0);

      // reset in the middle of a frame
      send_bits(1'b0, 16);
      for (int i = 0; i < 3; i++) send_bits(frames[3][i], 16);
      reset = 1'b0;
      rx_in = 1'b0;
      #2;
      check("midrst_busy", rx_busy, 0);
      check("midrst_valid", rx_valid, 0);
      check("midrst_data", rx_data, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("low_after_reset_no_start", rx_busy, 0);
      send_bits(1'b1, 20);
      exp_q.push_back(8'hD3);
      send_frame(8'hD3, 1'b0, 1'b1);
      wait_drain("midrst_drain", 30);
      check("midrst_pe", pe_cnt, 1);
      check("midrst_fe", fe_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
